// File: rtl/aud_play_ctrl.sv
// Playback sequencer: fetches one SRAM sample per DAC frame and feeds the I2S serializer,
// with start/pause/stop control and fast (skip) / slow (zero-order hold) playback.
module aud_play_ctrl #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_fast,
  input  logic              i_slow,
  input  logic [2:0]        i_speed,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic              i_daclrck,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_rd,
  input  logic [DATA_W-1:0] i_sram_data,
  input  logic              i_sram_valid,
  output logic [DATA_W-1:0] o_dac_data,
  output logic              o_player_en,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {StIdle, StWait, StFetch, StPaused, StDone} state_e;

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [2:0]          r_rep_cnt, w_rep_nxt;
  logic [3:0]          r_step, w_step_nxt;
  logic                r_lrck;
  logic                r_sram_rd, w_rd_nxt;
  logic [DATA_W-1:0]   r_dac_data, w_dac_nxt;
  logic                r_player_en, r_busy, r_done;

  logic                w_tick, w_fast, w_slow, w_last;
  logic [3:0]          w_f;
  logic [ADDR_W:0]     w_sum;

  assign w_tick = i_daclrck & ~r_lrck;
  assign w_fast = i_fast & ~i_slow;
  assign w_slow = i_slow & ~i_fast;
  assign w_f    = {1'b0, i_speed} + 4'd1;
  // Extra MSB catches address overflow, which also ends playback.
  assign w_sum  = {1'b0, r_addr} + {{(ADDR_W-3){1'b0}}, r_step};
  assign w_last = w_sum > {1'b0, i_end_addr};

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_rep_nxt   = r_rep_cnt;
    w_step_nxt  = r_step;
    w_rd_nxt    = 1'b0;
    w_dac_nxt   = r_dac_data;
    if (r_state != StIdle && i_stop) begin
      w_state_nxt = StIdle;
      w_addr_nxt  = '0;
      w_rep_nxt   = '0;
      w_dac_nxt   = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            w_state_nxt = StWait;
            w_addr_nxt  = '0;
            w_rep_nxt   = '0;
          end
        end
        StWait: begin
          if (i_pause) begin
            w_state_nxt = StPaused;
            w_dac_nxt   = '0;
          end else if (w_tick) begin
            if (w_slow && (r_rep_cnt < i_speed)) begin
              w_rep_nxt = r_rep_cnt + 3'd1;
            end else begin
              w_rep_nxt   = '0;
              w_rd_nxt    = 1'b1;
              w_step_nxt  = w_fast ? w_f : 4'd1;
              w_state_nxt = StFetch;
            end
          end
        end
        StFetch: begin
          // Pausing abandons the read; addr is untouched so the sample is refetched.
          if (i_pause) begin
            w_state_nxt = StPaused;
            w_dac_nxt   = '0;
          end else if (i_sram_valid) begin
            w_dac_nxt = i_sram_data;
            if (w_last) begin
              w_state_nxt = StDone;
            end else begin
              w_addr_nxt  = w_sum[ADDR_W-1:0];
              w_state_nxt = StWait;
            end
          end
        end
        StPaused: begin
          if (i_start) w_state_nxt = StWait;
        end
        StDone: begin
          w_state_nxt = StIdle;
          w_addr_nxt  = '0;
          w_dac_nxt   = '0;
        end
        default: begin
          w_state_nxt = StIdle;
          w_addr_nxt  = '0;
          w_dac_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_rep_cnt   <= '0;
      r_step      <= 4'd1;
      r_lrck      <= 1'b0;
      r_sram_rd   <= 1'b0;
      r_dac_data  <= '0;
      r_player_en <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_rep_cnt   <= w_rep_nxt;
      r_step      <= w_step_nxt;
      r_lrck      <= i_daclrck;
      r_sram_rd   <= w_rd_nxt;
      r_dac_data  <= w_dac_nxt;
      r_player_en <= (w_state_nxt == StWait) || (w_state_nxt == StFetch);
      r_busy      <= (w_state_nxt != StIdle);
      r_done      <= (w_state_nxt == StDone);
    end
  end

  assign o_sram_addr = r_addr;
  assign o_sram_rd   = r_sram_rd;
  assign o_dac_data  = r_dac_data;
  assign o_player_en = r_player_en;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_aud_play_ctrl.sv
// Self-checking bench for aud_play_ctrl: table-driven and randomized playback runs checked
// against a frame-level model, plus pause/stop/reset corner sequences.
module tb_aud_play_ctrl;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 0, i_pause = 0, i_stop = 0, i_fast = 0, i_slow = 0;
  logic [2:0]  i_speed = '0;
  logic [19:0] i_end_addr = '0;
  logic        i_daclrck = 0;
  logic [19:0] o_sram_addr;
  logic        o_sram_rd;
  logic [15:0] i_sram_data = '0;
  logic        i_sram_valid = 0;
  logic [15:0] o_dac_data;
  logic        o_player_en, o_busy, o_done;

  aud_play_ctrl #(.ADDR_W(20), .DATA_W(16)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
    .i_fast(i_fast), .i_slow(i_slow), .i_speed(i_speed), .i_end_addr(i_end_addr),
    .i_daclrck(i_daclrck), .o_sram_addr(o_sram_addr), .o_sram_rd(o_sram_rd),
    .i_sram_data(i_sram_data), .i_sram_valid(i_sram_valid), .o_dac_data(o_dac_data),
    .o_player_en(o_player_en), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;
  int cyc = 0, tick_cnt = 0, tick_base = 0, lat = 1, done_cnt = 0;
  bit pend = 0;
  int pend_due = 0;
  logic [15:0] pend_data, dac_prev = '0, data_xor = '0;
  logic [19:0] rd_q[$];
  int          rdt_q[$];
  logic [15:0] dac_q[$];

  typedef struct {
    bit fast; bit slow; int speed; int end_a; int lat; int exp_n; int exp_last;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] data_of(input logic [19:0] a);
    return (16'h100 + a[15:0]) ^ data_xor;
  endfunction

  // One clock: sample outputs just after the edge, then drive LRCK and the SRAM response.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (o_sram_rd) begin
      rd_q.push_back(o_sram_addr);
      rdt_q.push_back(tick_cnt - tick_base - 1);
      pend = 1; pend_due = cyc + lat; pend_data = data_of(o_sram_addr);
    end
    if (o_done) done_cnt++;
    if (o_dac_data != dac_prev && o_dac_data != 0) dac_q.push_back(o_dac_data);
    dac_prev = o_dac_data;
    i_daclrck = (cyc % 8) >= 4;
    if (cyc % 8 == 4) tick_cnt++;
    i_sram_valid = 0;
    if (pend && pend_due == cyc) begin
      i_sram_valid = 1; i_sram_data = pend_data; pend = 0;
    end
  endtask

  task automatic align();
    while (cyc % 8 != 1) step();
  endtask

  task automatic clear_logs();
    rd_q.delete(); rdt_q.delete(); dac_q.delete();
    done_cnt = 0; pend = 0; dac_prev = o_dac_data;
  endtask

  task automatic pulse_start();
    tick_base = tick_cnt;
    i_start = 1; step(); i_start = 0;
  endtask

  task automatic wait_reads(input int n, input string nm);
    int k = 0;
    while (rd_q.size() < n && k < 600) begin step(); k++; end
    chk(nm, int'(rd_q.size() >= n), 1);
  endtask

  // Full playback run; expectations come from frame arithmetic, not the RTL's states.
  task automatic run_play(input bit f, input bit s, input int sp, input int ea, input int l,
                          input int exp_n, input int exp_last);
    int exp_a[$], exp_t[$];
    int ff, a, k, n;
    bit ef, es;
    ff = sp + 1; ef = f && !s; es = s && !f;
    a = 0; k = 0;
    while (a <= ea) begin
      exp_a.push_back(a);
      exp_t.push_back(es ? k * ff + ff - 1 : k);
      a += ef ? ff : 1; k++;
    end
    i_fast = f; i_slow = s; i_speed = 3'(sp); i_end_addr = 20'(ea); lat = l;
    align(); clear_logs(); pulse_start();
    chk("busy_on_start", o_busy, 1);
    chk("en_on_start", o_player_en, 1);
    n = 0;
    while (!o_done && n < 3000) begin step(); n++; end
    chk("done_seen", o_done, 1);
    chk("busy_in_done", o_busy, 1);
    chk("en_in_done", o_player_en, 0);
    step();
    chk("busy_after_done", o_busy, 0);
    chk("done_one_cycle", o_done, 0);
    chk("dac_after_done", o_dac_data, 0);
    repeat (10) step();
    chk("done_count", done_cnt, 1);
    if (exp_n >= 0) begin
      chk("tbl_reads", rd_q.size(), exp_n);
      if (rd_q.size() > 0) chk("tbl_last", rd_q[rd_q.size()-1], exp_last);
    end
    chk("n_reads", rd_q.size(), exp_a.size());
    chk("n_dac", dac_q.size(), exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) begin
      if (i < rd_q.size()) begin
        chk("rd_addr", rd_q[i], exp_a[i]);
        chk("rd_frame", rdt_q[i], exp_t[i]);
      end
      if (i < dac_q.size()) chk("dac_seq", dac_q[i], data_of(20'(exp_a[i])));
    end
  endtask

  initial begin
    vecs[0] = '{0, 0, 0, 3, 1, 4, 3};
    vecs[1] = '{1, 0, 2, 10, 1, 4, 9};
    vecs[2] = '{0, 1, 1, 1, 1, 2, 1};
    vecs[3] = '{1, 1, 5, 2, 2, 3, 2};
    vecs[4] = '{1, 0, 0, 2, 3, 3, 2};
    vecs[5] = '{0, 0, 3, 0, 1, 1, 0};
    vecs[6] = '{1, 0, 7, 8, 2, 2, 8};

    repeat (2) step();
    chk("rst_addr", o_sram_addr, 0);
    chk("rst_rd", o_sram_rd, 0);
    chk("rst_dac", o_dac_data, 0);
    chk("rst_en", o_player_en, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    i_rst = 0;
    repeat (3) step();

    for (int v = 0; v < 7; v++)
      run_play(vecs[v].fast, vecs[v].slow, vecs[v].speed, vecs[v].end_a, vecs[v].lat,
               vecs[v].exp_n, vecs[v].exp_last);

    for (int r = 0; r < 8; r++) begin
      data_xor = 16'($urandom_range(1, 127) << 9);
      run_play(1'($urandom), 1'($urandom), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 10)), int'($urandom_range(1, 3)), -1, 0);
    end
    data_xor = '0;

    // Pause while the fetch of addr 5 is outstanding; its late valid must be dropped.
    i_fast = 0; i_slow = 0; i_end_addr = 20'd10; lat = 3;
    align(); clear_logs(); pulse_start();
    begin
      int n = 0;
      while (!(o_sram_rd && o_sram_addr == 20'd5) && n < 600) begin step(); n++; end
      chk("pause_reach5", int'(n < 600), 1);
    end
    i_pause = 1; step(); i_pause = 0;
    chk("pause_en", o_player_en, 0);
    chk("pause_dac", o_dac_data, 0);
    chk("pause_busy", o_busy, 1);
    repeat (8) step();
    chk("pause_dac_late", o_dac_data, 0);
    chk("pause_en_late", o_player_en, 0);
    chk("pause_addr_held", o_sram_addr, 5);
    clear_logs(); pulse_start();
    wait_reads(1, "resume_read");
    if (rd_q.size() > 0) chk("resume_addr", rd_q[0], 5);
    repeat (6) step();
    chk("resume_dac", o_dac_data, data_of(20'd5));
    i_stop = 1; step(); i_stop = 0;
    chk("stop_busy", o_busy, 0);

    // Stop and pause together mid-play: stop wins, no done pulse.
    lat = 1;
    align(); clear_logs(); pulse_start();
    wait_reads(2, "sp_reads");
    repeat (2) step();
    i_stop = 1; i_pause = 1; step(); i_stop = 0; i_pause = 0;
    chk("sp_busy", o_busy, 0);
    chk("sp_addr", o_sram_addr, 0);
    chk("sp_en", o_player_en, 0);
    chk("sp_dac", o_dac_data, 0);
    repeat (20) step();
    chk("sp_no_done", done_cnt, 0);
    chk("sp_still_idle", o_busy, 0);
    align(); clear_logs(); pulse_start();
    wait_reads(1, "sp_restart");
    if (rd_q.size() > 0) chk("sp_restart_addr", rd_q[0], 0);
    i_stop = 1; step(); i_stop = 0;

    // Asynchronous reset while a fetch is pending.
    lat = 2;
    align(); clear_logs(); pulse_start();
    wait_reads(2, "rst_reads");
    chk("rst_pre_dac", o_dac_data, data_of(20'd0));
    i_rst = 1; #1;
    chk("arst_addr", o_sram_addr, 0);
    chk("arst_rd", o_sram_rd, 0);
    chk("arst_dac", o_dac_data, 0);
    chk("arst_en", o_player_en, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_done", o_done, 0);
    step(); i_rst = 0;
    repeat (6) step();
    chk("post_rst_dac", o_dac_data, 0);
    chk("post_rst_busy", o_busy, 0);
    chk("post_rst_en", o_player_en, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/aud_play_ctrl.md
Name: aud_play_ctrl

Overview:
- Playback sequencer between the SRAM recording buffer and the I2S DAC serializer.
- Fetches one 16-bit sample per DAC frame, gates the serializer enable, and implements start/pause/stop.
- Supports variable-speed playback: fast mode skips samples; slow mode repeats each sample (zero-order hold).
- Runs in the BCLK domain; i_daclrck is synchronous to i_clk.

Parameters:
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, sample width

Ports:
- i_clk  in  1  BCLK-domain clock
- i_rst  in  1  asynchronous active-high reset
- i_start  in  1  1-cycle pulse: begin playback from IDLE or resume from PAUSED
- i_pause  in  1  1-cycle pulse: pause during playback
- i_stop  in  1  1-cycle pulse: abort playback, return to IDLE
- i_fast  in  1  fast mode select
- i_slow  in  1  slow mode select
- i_speed  in  3  speed factor F = i_speed+1 (1..8)
- i_end_addr  in  ADDR_W  last valid sample address (inclusive)
- i_daclrck  in  1  DAC LR clock; rising edge = frame tick
- o_sram_addr  out  ADDR_W  read address
- o_sram_rd  out  1  read strobe, 1 cycle per fetch
- i_sram_data  in  DATA_W  read data
- i_sram_valid  in  1  read data valid, 1 cycle, arbitrary latency >= 1
- o_dac_data  out  DATA_W  sample to serializer
- o_player_en  out  1  serializer enable
- o_busy  out  1  high in any state other than IDLE
- o_done  out  1  1-cycle pulse when end address is passed

Behaviour:
- Reset values: o_sram_addr=0, o_sram_rd=0, o_dac_data=0, o_player_en=0, o_busy=0, o_done=0. Internal state: IDLE, rep_cnt=0, lrck_d=0.
- Frame tick: i_daclrck==1 && lrck_d==0, where lrck_d is i_daclrck registered on i_clk.
- States:
  - IDLE: i_start -> WAIT; addr=0, rep_cnt=0.
  - WAIT: o_player_en=1. On a frame tick:
    - If slow mode is effective and rep_cnt < F-1: rep_cnt++, no fetch, o_dac_data held, stay in WAIT.
    - Otherwise: rep_cnt=0, pulse o_sram_rd for one cycle with o_sram_addr=addr, go to FETCH.
  - FETCH: o_player_en=1. On i_sram_valid:
    - o_dac_data<=i_sram_data.
    - addr += step (fast: F; otherwise 1), computed in ADDR_W+1 bits.
    - If the new addr > i_end_addr: go to DONE. Else go to WAIT.
    - Frame ticks arriving during FETCH are ignored; no fetch is queued.
  - PAUSED: o_player_en=0, o_dac_data=0, addr and rep_cnt held. i_start -> WAIT.
  - DONE: o_done=1 for exactly one cycle, o_player_en=0, o_dac_data=0, then IDLE.
- Mode rules:
  - Effective mode: fast if i_fast&&!i_slow; slow if i_slow&&!i_fast; otherwise normal (both high = normal).
  - F=1 in fast or slow mode behaves exactly as normal.
  - Mode and F are sampled at each frame tick, so changes take effect at the next frame.
- Control priority in the same cycle: i_rst > i_stop > i_pause > i_start.
  - i_stop in any non-IDLE state -> IDLE, addr=0, all outputs at reset values, no o_done.
  - i_pause in WAIT or FETCH -> PAUSED. A fetch in flight is abandoned, addr is not advanced, and the sample is refetched on resume.
  - Any i_sram_valid arriving while not in FETCH is ignored.
  - i_start in WAIT/FETCH, and i_pause in IDLE/PAUSED/DONE, are ignored.
- Latency:
  - o_sram_rd asserts the cycle after the frame tick.
  - o_dac_data updates the cycle after i_sram_valid.
  - The serializer uses the sample at the following frame, giving one frame of latency by design.
- Address arithmetic:
  - No wrap-around: overflow past 2^ADDR_W-1 via the extra bit also triggers DONE.
  - i_end_addr=0 plays exactly one sample.
- o_busy = (state != IDLE), registered.

Test Plan:
- Normal playback, i_end_addr=3, 1-cycle SRAM latency, data=addr+0x100 -> reads at addr 0,1,2,3 on consecutive frames; o_dac_data sequence 0x100..0x103; o_done pulses once after the 4th valid; o_busy falls the cycle after.
- Fast mode, i_speed=2 (F=3), i_end_addr=10 -> reads at 0,3,6,9, then DONE (12>10); exactly 4 o_sram_rd pulses.
- Slow mode, i_speed=1 (F=2), i_end_addr=1 -> each sample held 2 frames: reads at frames 1 and 3 only, o_dac_data 0x100,0x100,0x101,0x101.
- Pause during FETCH at addr 5, valid arriving after the pause, then i_start -> valid ignored, o_player_en=0 and o_dac_data=0 while paused; the first read after resume is addr 5.
- i_stop and i_pause in the same cycle mid-play -> IDLE, o_sram_addr=0, no o_done; the next i_start reads addr 0.
- Assert i_rst while in FETCH -> all outputs return to reset values immediately (asynchronous); a later i_sram_valid has no effect.
